pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Takes hazard inputs from IF, ID, EX and MEM:
  - load-use hazards, detected against an internally tracked load in EX;
  - taken-branch redirects from EX;
  - memory busy from IF and MEM.
- Produces a per-stage-register hold vector, flush strobes and the PC redirect.
- Discards an in-flight fetch that returns after a redirect.

Parameters:
- XLEN, 32, data/address width.
- REG_AW, 5, register address width.
- CNT_W, 32, width of the performance counters (optional feature).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous reset, active-high.
- rdy_in  in  1  global ready; low freezes the pipeline.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_en  in  1  ID reads rs1 (read_flag_1 from ID).
- id_rs1  in  REG_AW  rs1 address.
- id_rs2_en  in  1  ID reads rs2 (read_flag_2 from ID).
- id_rs2  in  REG_AW  rs2 address.
- id_is_load  in  1  ID instruction is a LOAD.
- id_rd  in  REG_AW  ID destination register.
- ex_br_taken  in  1  EX resolved a taken branch/jump.
- ex_br_target  in  XLEN  redirect address.
- if_busy  in  1  instruction fetch outstanding.
- mem_busy  in  1  MEM stage waiting on memory.
- stall  out  5  hold vector:
  - bit0 = PC, bit1 = IF/ID, bit2 = ID/EX, bit3 = EX/MEM, bit4 = MEM/WB;
  - a held bit followed by a released bit inserts a bubble into the next register.
- flush_ifid  out  1  invalidate IF/ID.
- flush_idex  out  1  invalidate ID/EX.
- redirect_en  out  1  load PC with redirect_pc.
- redirect_pc  out  XLEN  target address.
- perf_stall_cnt  out  CNT_W  stall-cycle count (optional feature).
- perf_flush_cnt  out  CNT_W  redirect count (optional feature).

Behaviour:
- Reset (asynchronous): state = RUN, ld_ex_valid = 0, ld_ex_rd = 0, all outputs 0.
- All outputs are combinational from state, registers and inputs; there is no output latency.
- Registered state: state (RUN, DRAIN), ld_ex_valid, ld_ex_rd.
- Hazard resolution priority in RUN, evaluated each cycle:
  1. rdy_in = 0: stall = 11111; flushes and redirect 0; no register updates.
  2. mem_busy: stall = 01111; everything else 0; ld_ex registers hold.
  3. ex_br_taken:
     - stall = 00000, flush_ifid = flush_idex = 1, redirect_en = 1, redirect_pc = ex_br_target;
     - ld_ex_valid <= 0;
     - if if_busy, next state = DRAIN.
  4. Load-use:
     - condition: ld_ex_valid and id_valid and ((id_rs1_en and id_rs1 == ld_ex_rd) or (id_rs2_en and id_rs2 == ld_ex_rd));
     - response: stall = 00011 (bubble into ID/EX), ld_ex_valid <= 0;
     - lasts exactly one cycle; MEM forwarding covers the next cycle.
  5. if_busy: stall = 00001 (bubble into IF/ID).
  6. Otherwise: stall = 00000.
- ld_ex tracking:
  - when ID/EX advances with a non-bubble, ld_ex_valid <= id_valid and id_is_load and (id_rd != 0), and ld_ex_rd <= id_rd;
  - when a bubble enters ID/EX, ld_ex_valid <= 0.
- rd = x0 never raises a load-use stall.
- DRAIN state:
  - flush_ifid = 1 and stall = 00001 while if_busy, so the stale fetch is discarded;
  - when if_busy = 0, return to RUN; that cycle is evaluated as RUN.
  - mem_busy in DRAIN: stall = 01111 with flush_ifid still 1.
  - ex_br_taken cannot occur in DRAIN, because ID/EX holds a bubble.
- Simultaneous events:
  - branch + load-use: branch wins, no stall.
  - mem_busy + branch: branch deferred; EX is held, so the branch is re-presented.
- Reset mid-DRAIN returns to RUN with no redirect.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments every cycle with rdy_in = 1 and stall != 0;
  - perf_flush_cnt increments on each redirect_en;
  - both wrap modulo 2^CNT_W and reset to 0.
- Undefined: both ports are driven to constant 0 and no counter flops are built.

Decomposition:
- Shared defines file holds:
  - stall vector constants (STALL_NONE = 00000, STALL_IF = 00001, STALL_LU = 00011, STALL_MEM = 01111, STALL_ALL = 11111);
  - state encodings (RUN, DRAIN);
  - ZeroWord.
- One sub-module: pipe_perf_cnt, the wrapping counter with enable, instantiated twice under the macro.

Test Plan:
- Load x5 issued, next instruction reads x5 via rs2 -> one cycle with stall = 00011, then 00000; ld_ex_valid cleared.
- Load x0, next instruction reads x0 -> no stall.
- ex_br_taken with target 0x0000_1000 and if_busy = 1 for 3 cycles:
  - redirect_en pulses 1 cycle with redirect_pc = 0x1000;
  - flush_ifid stays high for 3 DRAIN cycles;
  - RUN follows.
- mem_busy held 4 cycles during a load-use condition -> stall = 01111 for 4 cycles, then 00011 for one cycle.
- rdy_in = 0 during a branch -> stall = 11111 and no redirect; rdy_in = 1 -> redirect occurs.
- With PIPE_CTRL_PERF_CNT_EN: 2 redirects and 5 stall cycles -> counters read 2 and 5; assert rst_in mid-DRAIN -> all counters and outputs read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage pipeline stall/flush scheduler:
//   - hold-vector constants (bit0 = PC, bit1 = IF/ID, bit2 = ID/EX,
//     bit3 = EX/MEM, bit4 = MEM/WB)
//   - scheduler state encoding (RUN, DRAIN)
//   - ZeroWord, the all-zero machine word
// Optional feature macro used by importers: PIPE_CTRL_PERF_CNT_EN
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int STALL_W      = 5;
    localparam int XLEN_DEFAULT = 32;

    // A held bit followed by a released bit pushes a bubble into the next
    // stage register, so each constant doubles as a bubble-insertion point.
    localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
    localparam logic [STALL_W-1:0] STALL_IF   = 5'b00001;
    localparam logic [STALL_W-1:0] STALL_LU   = 5'b00011;
    localparam logic [STALL_W-1:0] STALL_MEM  = 5'b01111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 5'b11111;

    localparam logic [XLEN_DEFAULT-1:0] ZeroWord = '0;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// Free-running wrapping event counter with enable.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears the count
//   en     in   count this cycle
//   count  out  W-bit count, wraps modulo 2^W
// -----------------------------------------------------------------------------
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Counter register; wrap-around is the natural overflow of the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush scheduler for the IF/ID/EX/MEM/WB pipeline. Tracks the
// load currently in EX to detect load-use hazards, applies taken-branch
// redirects, honours IF/MEM memory busy, and drains a fetch that is still in
// flight when a redirect happens so the stale instruction is discarded.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   rdy_in                    global ready, low freezes everything
//   id_valid, id_rs1_en, id_rs1, id_rs2_en, id_rs2, id_is_load, id_rd
//                             decode-stage instruction information
//   ex_br_taken, ex_br_target taken branch/jump resolved in EX
//   if_busy, mem_busy         fetch outstanding / MEM waiting on memory
//   stall[4:0]                hold vector (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   flush_ifid, flush_idex    invalidate strobes
//   redirect_en, redirect_pc  PC redirect
//   perf_stall_cnt, perf_flush_cnt
//                             performance counters, built only when
//                             PIPE_CTRL_PERF_CNT_EN is defined, else tied 0
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               id_valid,
    input  logic               id_rs1_en,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic               id_rs2_en,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic               id_is_load,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_br_taken,
    input  logic [XLEN-1:0]    ex_br_target,
    input  logic               if_busy,
    input  logic               mem_busy,
    output logic [STALL_W-1:0] stall,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic               redirect_en,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [CNT_W-1:0]   perf_stall_cnt,
    output logic [CNT_W-1:0]   perf_flush_cnt
);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic              ld_ex_valid;
    logic              ld_ex_valid_next;
    logic [REG_AW-1:0] ld_ex_rd;
    logic [REG_AW-1:0] ld_ex_rd_next;
    logic              load_use;

    // Load-use hazard: the load sitting in EX writes a register that the
    // instruction in ID wants to read. x0 loads are never tracked, so they
    // can never raise this.
    always_comb begin
        load_use = ld_ex_valid && id_valid &&
                   ((id_rs1_en && (id_rs1 == ld_ex_rd)) ||
                    (id_rs2_en && (id_rs2 == ld_ex_rd)));
    end

    // Hazard priority and next-state logic. While reset is asserted every
    // output is forced to 0 regardless of the hazard inputs. A DRAIN cycle
    // with the fetch already returned is handled exactly like RUN. Whenever
    // ID/EX advances with a real instruction the load tracker samples ID;
    // whenever a bubble or flush enters ID/EX the tracker is cleared.
    always_comb begin
        stall            = STALL_NONE;
        flush_ifid       = 1'b0;
        flush_idex       = 1'b0;
        redirect_en      = 1'b0;
        redirect_pc      = XLEN'(ZeroWord);
        state_next       = state;
        ld_ex_valid_next = ld_ex_valid;
        ld_ex_rd_next    = ld_ex_rd;

        if (!rst_in) begin
            if (!rdy_in) begin
                stall = STALL_ALL;
            end else if ((state == DRAIN) && if_busy) begin
                flush_ifid = 1'b1;
                if (mem_busy) begin
                    stall = STALL_MEM;
                end else begin
                    stall            = STALL_IF;
                    ld_ex_valid_next = id_valid && id_is_load && (id_rd != '0);
                    ld_ex_rd_next    = id_rd;
                end
            end else begin
                state_next = RUN;
                if (mem_busy) begin
                    // EX is held, so a pending branch is simply re-presented.
                    stall = STALL_MEM;
                end else if (ex_br_taken) begin
                    flush_ifid       = 1'b1;
                    flush_idex       = 1'b1;
                    redirect_en      = 1'b1;
                    redirect_pc      = ex_br_target;
                    ld_ex_valid_next = 1'b0;
                    if (if_busy) begin
                        state_next = DRAIN;
                    end
                end else if (load_use) begin
                    stall            = STALL_LU;
                    ld_ex_valid_next = 1'b0;
                end else begin
                    if (if_busy) begin
                        stall = STALL_IF;
                    end
                    ld_ex_valid_next = id_valid && id_is_load && (id_rd != '0);
                    ld_ex_rd_next    = id_rd;
                end
            end
        end
    end

    // State and load-tracker registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= RUN;
            ld_ex_valid <= 1'b0;
            ld_ex_rd    <= '0;
        end else begin
            state       <= state_next;
            ld_ex_valid <= ld_ex_valid_next;
            ld_ex_rd    <= ld_ex_rd_next;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    pipe_perf_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_in),
        .rst   (rst_in),
        .en    (rdy_in && (stall != STALL_NONE)),
        .count (perf_stall_cnt)
    );

    pipe_perf_cnt #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk_in),
        .rst   (rst_in),
        .en    (redirect_en),
        .count (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed self-checking bench for pipe_ctrl. Each cycle inputs are driven
// 1 ns after the rising edge and outputs are compared 1 ns later.
// Honours PIPE_CTRL_PERF_CNT_EN for the counter expectations.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk_in;
    logic              rst_in;
    logic              rdy_in;
    logic              id_valid;
    logic              id_rs1_en;
    logic [REG_AW-1:0] id_rs1;
    logic              id_rs2_en;
    logic [REG_AW-1:0] id_rs2;
    logic              id_is_load;
    logic [REG_AW-1:0] id_rd;
    logic              ex_br_taken;
    logic [XLEN-1:0]   ex_br_target;
    logic              if_busy;
    logic              mem_busy;
    logic [4:0]        stall;
    logic              flush_ifid;
    logic              flush_idex;
    logic              redirect_en;
    logic [XLEN-1:0]   redirect_pc;
    logic [CNT_W-1:0]  perf_stall_cnt;
    logic [CNT_W-1:0]  perf_flush_cnt;

    int checks;
    int errors;
    int exp_stall_cnt;
    int exp_flush_cnt;

    pipe_ctrl #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .id_valid       (id_valid),
        .id_rs1_en      (id_rs1_en),
        .id_rs1         (id_rs1),
        .id_rs2_en      (id_rs2_en),
        .id_rs2         (id_rs2),
        .id_is_load     (id_is_load),
        .id_rd          (id_rd),
        .ex_br_taken    (ex_br_taken),
        .ex_br_target   (ex_br_target),
        .if_busy        (if_busy),
        .mem_busy       (mem_busy),
        .stall          (stall),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    // 100 MHz clock.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Waits for the next rising edge, then drives one cycle of inputs.
    task automatic apply_stimulus(
        input logic            rdy,
        input logic            valid,
        input logic            rs1_en,
        input logic [4:0]      rs1,
        input logic            rs2_en,
        input logic [4:0]      rs2,
        input logic            is_load,
        input logic [4:0]      rd,
        input logic            br,
        input logic [XLEN-1:0] tgt,
        input logic            ifb,
        input logic            memb
    );
        @(posedge clk_in);
        #1;
        rdy_in       = rdy;
        id_valid     = valid;
        id_rs1_en    = rs1_en;
        id_rs1       = rs1;
        id_rs2_en    = rs2_en;
        id_rs2       = rs2;
        id_is_load   = is_load;
        id_rd        = rd;
        ex_br_taken  = br;
        ex_br_target = tgt;
        if_busy      = ifb;
        mem_busy     = memb;
        #1;
    endtask

    // Compares the control outputs and the performance counters. The counter
    // expectations come from a running tally of expected stall/redirect cycles.
    task automatic check_output(
        input string           tag,
        input logic [4:0]      e_stall,
        input logic            e_fi,
        input logic            e_fe,
        input logic            e_re,
        input logic [XLEN-1:0] e_pc
    );
        logic [CNT_W-1:0] want_sc;
        logic [CNT_W-1:0] want_fc;

        checks++;
        assert ({stall, flush_ifid, flush_idex, redirect_en, redirect_pc} ===
                {e_stall, e_fi, e_fe, e_re, e_pc})
        else begin
            errors++;
            $error("[TB] FAIL %s: got stall=%b fi=%b fe=%b re=%b pc=%h, expected stall=%b fi=%b fe=%b re=%b pc=%h",
                   tag, stall, flush_ifid, flush_idex, redirect_en, redirect_pc,
                   e_stall, e_fi, e_fe, e_re, e_pc);
        end

        if (rst_in) begin
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end
`ifdef PIPE_CTRL_PERF_CNT_EN
        want_sc = CNT_W'(exp_stall_cnt);
        want_fc = CNT_W'(exp_flush_cnt);
`else
        want_sc = '0;
        want_fc = '0;
`endif
        checks++;
        assert ({perf_stall_cnt, perf_flush_cnt} === {want_sc, want_fc})
        else begin
            errors++;
            $error("[TB] FAIL %s_perf: got stall_cnt=%0d flush_cnt=%0d, expected stall_cnt=%0d flush_cnt=%0d",
                   tag, perf_stall_cnt, perf_flush_cnt, want_sc, want_fc);
        end

        if (!rst_in) begin
            if (rdy_in && (e_stall != 5'b00000)) exp_stall_cnt++;
            if (e_re) exp_flush_cnt++;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;

        // Reset with hazards present: outputs must still be 0.
        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        id_valid     = 1'b0;
        id_rs1_en    = 1'b0;
        id_rs1       = '0;
        id_rs2_en    = 1'b0;
        id_rs2       = '0;
        id_is_load   = 1'b0;
        id_rd        = '0;
        ex_br_taken  = 1'b1;
        ex_br_target = 32'h0000_0abc;
        if_busy      = 1'b1;
        mem_busy     = 1'b0;
        #2;
        check_output("reset", 5'b00000, 0, 0, 0, 32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Load x5, then rs2 reads x5: one bubble, then release.
        apply_stimulus(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        check_output("lu_load", 5'b00000, 0, 0, 0, 32'h0);
        apply_stimulus(1, 1, 1, 3, 1, 5, 0, 6, 0, 0, 0, 0);
        check_output("lu_stall", 5'b00011, 0, 0, 0, 32'h0);
        apply_stimulus(1, 1, 1, 3, 1, 5, 0, 6, 0, 0, 0, 0);
        check_output("lu_release", 5'b00000, 0, 0, 0, 32'h0);

        // Load x0, then read x0: no hazard.
        apply_stimulus(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check_output("x0_load", 5'b00000, 0, 0, 0, 32'h0);
        apply_stimulus(1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        check_output("x0_use", 5'b00000, 0, 0, 0, 32'h0);

        // Load x7, then use via rs1 while MEM is busy for 4 cycles.
        apply_stimulus(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        check_output("mb_load", 5'b00000, 0, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 1, 1, 7, 0, 0, 0, 8, 0, 0, 0, 1);
            check_output($sformatf("mb_hold%0d", i), 5'b01111, 0, 0, 0, 32'h0);
        end
        apply_stimulus(1, 1, 1, 7, 0, 0, 0, 8, 0, 0, 0, 0);
        check_output("mb_lu", 5'b00011, 0, 0, 0, 32'h0);
        apply_stimulus(1, 1, 1, 7, 0, 0, 0, 8, 0, 0, 0, 0);
        check_output("mb_release", 5'b00000, 0, 0, 0, 32'h0);

        // Plain fetch busy.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_output("if_busy", 5'b00001, 0, 0, 0, 32'h0);

        // Branch with fetch outstanding, then 3 DRAIN cycles (one with mem_busy).
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_1000, 1, 0);
        check_output("br_redirect", 5'b00000, 1, 1, 1, 32'h0000_1000);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_output("drain1", 5'b00001, 1, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check_output("drain2_mem", 5'b01111, 1, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_output("drain3", 5'b00001, 1, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("drain_exit", 5'b00000, 0, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_output("run_ifb", 5'b00001, 0, 0, 0, 32'h0);

        // Branch together with load-use: branch wins, tracker cleared.
        apply_stimulus(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        check_output("bl_load", 5'b00000, 0, 0, 0, 32'h0);
        apply_stimulus(1, 1, 1, 9, 0, 0, 0, 10, 1, 32'h0000_2000, 0, 0);
        check_output("bl_branch", 5'b00000, 1, 1, 1, 32'h0000_2000);
        apply_stimulus(1, 1, 1, 9, 0, 0, 0, 10, 0, 0, 0, 0);
        check_output("bl_after", 5'b00000, 0, 0, 0, 32'h0);

        // mem_busy defers the branch; it is taken once MEM frees up.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_3000, 0, 1);
        check_output("mb_branch_held", 5'b01111, 0, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_3000, 0, 0);
        check_output("mb_branch_go", 5'b00000, 1, 1, 1, 32'h0000_3000);

        // rdy_in low freezes a pending branch; it redirects once ready.
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_4000, 1, 0);
        check_output("rdy_freeze", 5'b11111, 0, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_4000, 1, 0);
        check_output("rdy_branch", 5'b00000, 1, 1, 1, 32'h0000_4000);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_output("rdy_drain", 5'b00001, 1, 0, 0, 32'h0);

        // Reset in the middle of DRAIN: everything back to 0, then RUN.
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        check_output("rst_drain", 5'b00000, 0, 0, 0, 32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        check_output("post_reset_run", 5'b00001, 0, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
